// File: rtl/ascii_dec_emitter.sv
// Formats a binary integer as decimal ASCII text (optional '-' and terminator)
// on a byte valid/ready stream, most-significant digit first.
module ascii_dec_emitter #(
    parameter int         WIDTH     = 32,
    parameter int         DIGITS    = 10,
    parameter int         SIGNED    = 0,
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_BYTE = 8'h0A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_byte,
    output logic             out_last,
    output logic             busy
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SIGN,
        S_EMIT,
        S_TERM
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  shift_r;
    logic [BW-1:0]     bcd_r;
    logic [CW-1:0]     cnt_r;
    logic [IW-1:0]     idx_r;
    logic              neg_r;

    logic [BW-1:0]     bcd_adj_s;
    logic [BW-1:0]     bcd_nxt_s;
    logic [IW-1:0]     first_nxt_s;
    logic              neg_in_s;
    logic [WIDTH-1:0]  mag_in_s;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Index of the highest nonzero digit; 0 when every digit is zero.
    function automatic logic [IW-1:0] top_digit(input logic [BW-1:0] b);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] != 4'd0) begin
                r = IW'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [IW-1:0] idx);
        return 8'h30 + {4'h0, b[4*int'(idx) +: 4]};
    endfunction

    // Without a terminator the units digit closes the number.
    function automatic logic last_at(input logic [IW-1:0] idx);
        return (TERM_EN == 0) && (idx == '0);
    endfunction

    // Next BCD value for one conversion step and the input sign/magnitude split.
    always_comb begin
        bcd_adj_s   = dabble_adjust(bcd_r);
        bcd_nxt_s   = {bcd_adj_s[BW-2:0], shift_r[WIDTH-1]};
        first_nxt_s = top_digit(bcd_nxt_s);
        neg_in_s    = (SIGNED != 0) && in_data[WIDTH-1];
        if (neg_in_s) begin
            mag_in_s = ~in_data + WIDTH'(1);
        end else begin
            mag_in_s = in_data;
        end
    end

    // Control FSM with registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            shift_r   <= '0;
            bcd_r     <= '0;
            cnt_r     <= '0;
            idx_r     <= '0;
            neg_r     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_byte  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        state_r  <= S_CONV;
                        shift_r  <= mag_in_s;
                        neg_r    <= neg_in_s;
                        bcd_r    <= '0;
                        cnt_r    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_CONV: begin
                    bcd_r   <= bcd_nxt_s;
                    shift_r <= {shift_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        idx_r     <= first_nxt_s;
                        out_valid <= 1'b1;
                        if (neg_r) begin
                            state_r  <= S_SIGN;
                            out_byte <= 8'h2D;
                            out_last <= 1'b0;
                        end else begin
                            state_r  <= S_EMIT;
                            out_byte <= digit_char(bcd_nxt_s, first_nxt_s);
                            out_last <= last_at(first_nxt_s);
                        end
                    end
                end
                S_SIGN: begin
                    if (out_ready) begin
                        state_r  <= S_EMIT;
                        out_byte <= digit_char(bcd_r, idx_r);
                        out_last <= last_at(idx_r);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (idx_r != '0) begin
                            idx_r    <= idx_r - IW'(1);
                            out_byte <= digit_char(bcd_r, idx_r - IW'(1));
                            out_last <= last_at(idx_r - IW'(1));
                        end else if (TERM_EN != 0) begin
                            state_r  <= S_TERM;
                            out_byte <= TERM_BYTE;
                            out_last <= 1'b1;
                        end else begin
                            state_r   <= S_IDLE;
                            out_valid <= 1'b0;
                            out_byte  <= 8'h00;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                S_TERM: begin
                    if (out_ready) begin
                        state_r   <= S_IDLE;
                        out_valid <= 1'b0;
                        out_byte  <= 8'h00;
                        out_last  <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    out_valid <= 1'b0;
                    out_byte  <= 8'h00;
                    out_last  <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_dec_emitter.sv
// Self-checking bench: three emitter configurations against a division-based text model.
module tb_ascii_dec_emitter;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst;
    logic [2:0]  iv;
    logic [31:0] in_data;
    logic        out_ready;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  ol;
    wire  [2:0]  bz;
    wire  [23:0] ob_all;
    int          sel;
    int          tests;
    int          fails;
    bq_t         cap_q;
    bq_t         caplast_q;

    // Instance 0: unsigned+terminator, 1: signed+terminator, 2: unsigned, no terminator
    ascii_dec_emitter #(.WIDTH(32), .DIGITS(10), .SIGNED(0), .TERM_EN(1), .TERM_BYTE(8'h0A)) u_uns (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_byte(ob_all[7:0]), .out_last(ol[0]), .busy(bz[0]));
    ascii_dec_emitter #(.WIDTH(32), .DIGITS(10), .SIGNED(1), .TERM_EN(1), .TERM_BYTE(8'h0A)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_byte(ob_all[15:8]), .out_last(ol[1]), .busy(bz[1]));
    ascii_dec_emitter #(.WIDTH(32), .DIGITS(10), .SIGNED(0), .TERM_EN(0), .TERM_BYTE(8'h0A)) u_nt (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_byte(ob_all[23:16]), .out_last(ol[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ob_sel();
        return ob_all[8*sel +: 8];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    function automatic string q2s(input bq_t q);
        string s;
        s = "";
        foreach (q[i]) begin
            if (q[i] >= 8'h20 && q[i] < 8'h7F) s = {s, $sformatf("%c", q[i])};
            else s = {s, $sformatf("<%02h>", q[i])};
        end
        return s;
    endfunction

    // Reference text: repeated division by ten on the exact magnitude.
    function automatic bq_t model(input logic [31:0] v, input bit sgn, input bit term);
        bq_t    q;
        longint mag;
        bit     neg;
        neg = sgn && v[31];
        mag = neg ? (64'h1_0000_0000 - longint'({32'h0, v})) : longint'({32'h0, v});
        if (mag == 0) q.push_back(8'h30);
        while (mag > 0) begin
            q.push_front(8'h30 + 8'(mag % 10));
            mag = mag / 10;
        end
        if (neg) q.push_front(8'h2D);
        if (term) q.push_back(8'h0A);
        return q;
    endfunction

    // Digit-run parser as used on the receive side.
    function automatic longint parse(input bq_t q);
        bit     neg;
        longint acc;
        neg = 1'b0;
        acc = 0;
        foreach (q[i]) begin
            if (q[i] == 8'h2D) neg = 1'b1;
            else if (q[i] >= 8'h30 && q[i] <= 8'h39) acc = acc * 10 + longint'(q[i] - 8'h30);
        end
        return neg ? -acc : acc;
    endfunction

    task automatic send(input int s, input logic [31:0] v, output bit ok);
        int n;
        n = 0;
        sel = s;
        while (!ir[sel] && n < 300) begin
            @(posedge clk); #1; n++;
        end
        ok = ir[sel];
        in_data = v;
        iv = 3'b001 << s;
        @(posedge clk); #1;
        iv = 3'b000;
    endtask

    task automatic collect(input int pct, output int first_edge, output int span,
                           output int stall_bad, output int ir_bad, output bit timeout);
        int         n;
        bit         done;
        bit         prev_stall;
        logic [7:0] prev_b;
        logic       prev_l;
        cap_q.delete();
        caplast_q.delete();
        first_edge = -1; span = 0; stall_bad = 0; ir_bad = 0;
        done = 1'b0; prev_stall = 1'b0; prev_b = 8'h00; prev_l = 1'b0; n = 0;
        while (!done && n < 400) begin
            out_ready = ($urandom_range(99) < pct);
            if (prev_stall && (!ov[sel] || ob_sel() !== prev_b || ol[sel] !== prev_l)) stall_bad++;
            if (ov[sel] && first_edge < 0) first_edge = n + 1;
            if (ir[sel]) ir_bad++;
            if (ov[sel] && out_ready) begin
                cap_q.push_back(ob_sel());
                caplast_q.push_back({7'h00, ol[sel]});
                if (ol[sel]) begin
                    done = 1'b1;
                    span = n - first_edge + 2;
                end
            end
            prev_stall = ov[sel] && !out_ready;
            prev_b = ob_sel();
            prev_l = ol[sel];
            @(posedge clk); #1; n++;
        end
        out_ready = 1'b0;
        timeout = !done;
    endtask

    task automatic run(input int s, input logic [31:0] v, input int pct, input string tag,
                       output int first_edge, output int span);
        bit     ok;
        bit     to;
        int     sb;
        int     irb;
        bq_t    exp_q;
        string  exp_last;
        string  got_last;
        longint exp_val;
        send(s, v, ok);
        chk({tag, "/accept"}, 64'(ok), 64'd1);
        chk({tag, "/busy"}, 64'(bz[sel]), 64'd1);
        collect(pct, first_edge, span, sb, irb, to);
        exp_q = model(v, s == 1, s != 2);
        exp_last = "";
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == exp_q.size() - 1) exp_last = {exp_last, "1"};
            else exp_last = {exp_last, "0"};
        end
        got_last = "";
        foreach (caplast_q[i]) got_last = {got_last, (caplast_q[i] != 8'h00) ? "1" : "0"};
        chk_str({tag, "/text"}, q2s(cap_q), q2s(exp_q));
        chk_str({tag, "/last"}, got_last, exp_last);
        chk({tag, "/timeout"}, 64'(to), 64'd0);
        chk({tag, "/stall_stable"}, 64'(sb), 64'd0);
        chk({tag, "/in_ready_low"}, 64'(irb), 64'd0);
        chk({tag, "/in_ready_after"}, 64'(ir[sel]), 64'd1);
        exp_val = (s == 1) ? longint'($signed(v)) : longint'({32'h0, v});
        chk({tag, "/roundtrip"}, 64'(parse(cap_q)), 64'(exp_val));
    endtask

    initial begin
        int         fe;
        int         sp;
        int         got;
        int         n;
        bit         ok;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [31:0] v;

        tests = 0; fails = 0; sel = 0;
        rst = 1'b1; iv = 3'b000; in_data = 32'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            chk($sformatf("reset%0d/in_ready", s), 64'(ir[sel]), 64'd1);
            chk($sformatf("reset%0d/out_valid", s), 64'(ov[sel]), 64'd0);
            chk($sformatf("reset%0d/out_byte", s), 64'(ob_sel()), 64'd0);
            chk($sformatf("reset%0d/out_last", s), 64'(ol[sel]), 64'd0);
            chk($sformatf("reset%0d/busy", s), 64'(bz[sel]), 64'd0);
        end

        run(0, 32'd0, 100, "uns_zero", fe, sp);
        run(0, 32'hFFFF_FFFF, 100, "uns_max", fe, sp);
        chk("uns_max/latency", 64'(fe), 64'd33);
        chk("uns_max/back_to_back", 64'(sp), 64'd11);

        run(1, 32'h8000_0000, 100, "sgn_min", fe, sp);
        run(1, 32'hFFFF_FFF9, 100, "sgn_m7", fe, sp);
        chk("sgn_m7/latency", 64'(fe), 64'd33);
        run(0, 32'd1234, 50, "bp_1234", fe, sp);

        // Abort in the middle of the digit run
        send(0, 32'd1234, ok);
        chk("rst_mid/accept", 64'(ok), 64'd1);
        out_ready = 1'b1;
        got = 0; n = 0; b0 = 8'h00; b1 = 8'h00;
        while (got < 2 && n < 200) begin
            if (ov[0]) begin
                if (got == 0) b0 = ob_all[7:0];
                else b1 = ob_all[7:0];
                got++;
            end
            @(posedge clk); #1; n++;
        end
        chk("rst_mid/byte0", 64'(b0), 64'h31);
        chk("rst_mid/byte1", 64'(b1), 64'h32);
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("rst_mid/out_valid_async", 64'(ov[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid/out_valid", 64'(ov[0]), 64'd0);
        chk("rst_mid/in_ready", 64'(ir[0]), 64'd1);
        chk("rst_mid/busy", 64'(bz[0]), 64'd0);
        run(0, 32'd56, 100, "rst_mid_56", fe, sp);

        run(2, 32'd9, 100, "nt_9", fe, sp);
        chk("nt_9/bytes", 64'(cap_q.size()), 64'd1);

        for (int i = 0; i < 1000 && fails < 50; i++) begin
            case ($urandom_range(3))
                0: v = $urandom;
                1: v = 32'($urandom_range(999));
                2: v = 32'h8000_0000 ^ 32'($urandom_range(3));
                default: v = 32'hFFFF_FFFF - 32'($urandom_range(3));
            endcase
            run(i % 3, v, $urandom_range(100, 40), $sformatf("rand%0d_%08h", i, v), fe, sp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
